// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: instruction fetch sequencer for a small 16-bit processor.
// It fetches one instruction word, and a second (immediate) word for mvi,
// from a synchronous-read instruction memory. It then pulses Run to the
// control unit and holds the proper word on DIN until Done is returned.
//
// Optional feature: define WATCHDOG_EN to enable a 4-bit EXEC watchdog.
// The watchdog raises Error and parks the sequencer in HALT when Done never
// arrives. When WATCHDOG_EN is undefined, EXEC waits forever and Error is tied to 0.
module instr_fetch_seq (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Pause,
  input  logic        Done,
  input  logic [15:0] MemData,
  output logic [4:0]  MemAddr,
  output logic [15:0] DIN,
  output logic        Run,
  output logic [4:0]  PC,
  output logic        Busy,
  output logic        Halted,
  output logic        Error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_LATCH_IMM = 3'd4,
    S_ISSUE     = 3'd5,
    S_EXEC      = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_pc;
  logic [4:0]  w_pc_next;
  logic [15:0] r_instr;
  logic [15:0] w_instr_next;
  logic [15:0] r_imm;
  logic [15:0] w_imm_next;
  logic [4:0]  r_mem_addr;
  logic [4:0]  w_mem_addr_next;
  logic [15:0] r_din;
  logic [15:0] w_din_next;
  logic        r_run;
  logic        w_run_next;
  logic        r_busy;
  logic        w_busy_next;
  logic        r_halted;
  logic        w_halted_next;
  logic        w_is_mvi;

`ifdef WATCHDOG_EN
  logic [3:0]  r_wd_cnt;
  logic [3:0]  w_wd_cnt_next;
  logic        r_error;
  logic        w_error_next;
`endif

  assign w_is_mvi = (r_instr[8:6] == OP_MVI);

  // Next-state decode plus next values for every registered output.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_imm_next   = r_imm;
`ifdef WATCHDOG_EN
    w_wd_cnt_next = r_wd_cnt;
    w_error_next  = r_error;
`endif

    case (r_state)
      S_IDLE: begin
        if (Start && !Pause) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_state_next = S_LATCH;
      end
      S_LATCH: begin
        // Memory data for the address presented in FETCH is valid now.
        w_instr_next = MemData;
        w_pc_next    = r_pc + 5'd1;
        if (MemData[8:6] == OP_HALT)     w_state_next = S_HALT;
        else if (MemData[8:6] == OP_MVI) w_state_next = S_FETCH_IMM;
        else                             w_state_next = S_ISSUE;
      end
      S_FETCH_IMM: begin
        w_state_next = S_LATCH_IMM;
      end
      S_LATCH_IMM: begin
        w_imm_next   = MemData;
        w_pc_next    = r_pc + 5'd1;
        w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        // Done is deliberately not looked at here: the control unit has not started yet.
        w_state_next = S_EXEC;
`ifdef WATCHDOG_EN
        w_wd_cnt_next = 4'd0;
`endif
      end
      S_EXEC: begin
        if (Done) begin
          w_state_next = Pause ? S_IDLE : S_FETCH;
        end
`ifdef WATCHDOG_EN
        else if (r_wd_cnt == 4'd14) begin
          // Fifteenth EXEC cycle without Done: give up on this instruction.
          w_wd_cnt_next = 4'd15;
          w_error_next  = 1'b1;
          w_state_next  = S_HALT;
        end else begin
          w_wd_cnt_next = r_wd_cnt + 4'd1;
        end
`endif
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // MemAddr is loaded only on entry to a fetch state, so it holds in IDLE/HALT.
    w_mem_addr_next = r_mem_addr;
    if (w_state_next == S_FETCH || w_state_next == S_FETCH_IMM)
      w_mem_addr_next = w_pc_next;

    // DIN: instruction word through ISSUE and the first EXEC cycle, then the immediate for mvi.
    w_din_next = r_din;
    if (w_state_next == S_ISSUE)
      w_din_next = w_instr_next;
    else if (r_state == S_ISSUE)
      w_din_next = r_instr;
    else if (r_state == S_EXEC && w_state_next == S_EXEC)
      w_din_next = w_is_mvi ? r_imm : r_instr;

    w_run_next    = (w_state_next == S_ISSUE);
    w_busy_next   = (w_state_next != S_IDLE) && (w_state_next != S_HALT);
    w_halted_next = (w_state_next == S_HALT);
  end

  // State and output registers; Reset overrides everything, including mid-EXEC.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pc       <= 5'd0;
      r_instr    <= 16'd0;
      r_imm      <= 16'd0;
      r_mem_addr <= 5'd0;
      r_din      <= 16'd0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
`ifdef WATCHDOG_EN
      r_wd_cnt   <= 4'd0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_imm      <= w_imm_next;
      r_mem_addr <= w_mem_addr_next;
      r_din      <= w_din_next;
      r_run      <= w_run_next;
      r_busy     <= w_busy_next;
      r_halted   <= w_halted_next;
`ifdef WATCHDOG_EN
      r_wd_cnt   <= w_wd_cnt_next;
      r_error    <= w_error_next;
`endif
    end
  end

  assign MemAddr = r_mem_addr;
  assign DIN     = r_din;
  assign Run     = r_run;
  assign PC      = r_pc;
  assign Busy    = r_busy;
  assign Halted  = r_halted;
`ifdef WATCHDOG_EN
  assign Error   = r_error;
`else
  assign Error   = 1'b0;
`endif

endmodule
